morra_cinese_param: RTL

- Parametrised successor of the two-player rock-paper-scissors (morra cinese) referee.
- Scores one round (manche) per clock from two 2-bit moves and tracks the lead between the players.
- Enforces a minimum and a configurable maximum match length, plus an optional no-repeat rule.
- Reports the per-round result and the final match result. Sits between the player input decode and the score display logic.

---
 rtl/morra_cinese_param.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/morra_cinese_param.sv
`default_nettype none
// ============================================================================
//  Module   : morra_cinese_param
//  Purpose  : Two-player rock-paper-scissors referee. Scores one round per
//             clock, tracks the lead between the players and ends the match
//             either on a lead of LEAD (after MIN_ROUNDS) or on a
//             configurable round limit. An optional rule forbids the previous
//             round's winner from replaying its winning move.
//  Ports    : clk, rst_n (async, active low)
//             INIZIA           start/restart; {PRIMO,SECONDO} loads max length
//             PRIMO, SECONDO   moves: 00 none, 01 rock, 10 paper, 11 scissors
//             MANCHE           round result: 00 none, 01 P1, 10 P2, 11 draw
//             PARTITA          match result: 00 running, 01 P1, 10 P2, 11 draw
//             NUM_MANCHE       valid rounds played in the current match
//             DIFF             signed lead, positive when P1 is ahead
//  Revision : 1.0 - initial release
// ============================================================================
module morra_cinese_param #(
    parameter int CNT_W      = 5,
    parameter int MIN_ROUNDS = 4,
    parameter int LEAD       = 2,
    parameter int NO_REPEAT  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           INIZIA,
    input  logic [1:0]                     PRIMO,
    input  logic [1:0]                     SECONDO,
    output logic [1:0]                     MANCHE,
    output logic [1:0]                     PARTITA,
    output logic [CNT_W-1:0]               NUM_MANCHE,
    output logic signed [$clog2(LEAD)+1:0] DIFF
);

    localparam int LW = $clog2(LEAD) + 2;

    localparam logic signed [LW-1:0] c_lead_pos = LW'(LEAD);
    localparam logic signed [LW-1:0] c_lead_neg = -c_lead_pos;
    localparam logic signed [LW-1:0] c_sat_pos  = LW'(LEAD - 1);
    localparam logic signed [LW-1:0] c_sat_neg  = -c_sat_pos;
    localparam logic [CNT_W-1:0]     c_min      = CNT_W'(MIN_ROUNDS);

    localparam logic [1:0] c_none     = 2'b00;
    localparam logic [1:0] c_p1       = 2'b01;
    localparam logic [1:0] c_p2       = 2'b10;
    localparam logic [1:0] c_draw     = 2'b11;
    localparam logic [1:0] c_rock     = 2'b01;
    localparam logic [1:0] c_paper    = 2'b10;
    localparam logic [1:0] c_scissors = 2'b11;

    // Parameter sanity checks at elaboration
    if (LEAD < 1) begin : g_chk_lead
        $error("morra_cinese_param: LEAD must be >= 1");
    end
    if (MIN_ROUNDS < 1) begin : g_chk_min
        $error("morra_cinese_param: MIN_ROUNDS must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(MIN_ROUNDS + 15)) begin : g_chk_cnt
        $error("morra_cinese_param: CNT_W too narrow for MIN_ROUNDS+15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               r_state,     w_state;
    logic [CNT_W-1:0]     r_max,       w_max;
    logic [CNT_W-1:0]     r_num,       w_num;
    logic signed [LW-1:0] r_diff,      w_diff;
    logic [1:0]           r_manche,    w_manche;
    logic [1:0]           r_partita,   w_partita;
    logic [1:0]           r_last_win,  w_last_win;
    logic [1:0]           r_last_move, w_last_move;

    logic                 w_p1_beats;
    logic [1:0]           w_result;
    logic                 w_repeat;
    logic                 w_invalid;
    logic [CNT_W-1:0]     w_n;
    logic signed [LW-1:0] w_dnew;
    logic                 w_hit_lead;
    logic                 w_dnew_pos;

    // Round decode: rock > scissors > paper > rock
    assign w_p1_beats = ((PRIMO == c_rock)     && (SECONDO == c_scissors)) ||
                        ((PRIMO == c_scissors) && (SECONDO == c_paper))    ||
                        ((PRIMO == c_paper)    && (SECONDO == c_rock));
    assign w_result   = (PRIMO == SECONDO) ? c_draw : (w_p1_beats ? c_p1 : c_p2);

    // Last winner replaying the move it won with (record is empty after a draw)
    assign w_repeat   = (NO_REPEAT != 0) &&
                        (((r_last_win == c_p1) && (PRIMO   == r_last_move)) ||
                         ((r_last_win == c_p2) && (SECONDO == r_last_move)));
    assign w_invalid  = (PRIMO == 2'b00) || (SECONDO == 2'b00) || w_repeat;

    assign w_n        = r_num + CNT_W'(1);

    // Lead before saturation; never exceeds +/-LEAD since play stops there
    always_comb begin
        w_dnew = r_diff;
        if (w_result == c_p1) begin
            w_dnew = r_diff + LW'(1);
        end else if (w_result == c_p2) begin
            w_dnew = r_diff - LW'(1);
        end
    end

    assign w_hit_lead = (w_dnew >= c_lead_pos) || (w_dnew <= c_lead_neg);
    assign w_dnew_pos = !w_dnew[LW-1];

    always_comb begin
        w_state     = r_state;
        w_max       = r_max;
        w_num       = r_num;
        w_diff      = r_diff;
        w_manche    = r_manche;
        w_partita   = r_partita;
        w_last_win  = r_last_win;
        w_last_move = r_last_move;

        if (INIZIA) begin
            // Moves on a start cycle only carry the match length
            w_max       = CNT_W'({PRIMO, SECONDO}) + c_min;
            w_num       = '0;
            w_diff      = '0;
            w_last_win  = c_none;
            w_last_move = 2'b00;
            w_manche    = c_none;
            w_partita   = c_none;
            w_state     = ST_PLAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_manche = c_none;
                end
                ST_PLAY: begin
                    if (w_invalid) begin
                        w_manche = c_none;
                    end else begin
                        w_num    = w_n;
                        w_manche = w_result;
                        if (w_result == c_draw) begin
                            w_last_win  = c_none;
                            w_last_move = 2'b00;
                        end else begin
                            w_last_win  = w_result;
                            w_last_move = (w_result == c_p1) ? PRIMO : SECONDO;
                        end
                        if (w_hit_lead && (w_n >= c_min)) begin
                            w_partita = w_dnew_pos ? c_p1 : c_p2;
                            w_diff    = w_dnew_pos ? c_lead_pos : c_lead_neg;
                            w_state   = ST_OVER;
                        end else begin
                            // Too early to win by lead: hold one short of it
                            w_diff = w_hit_lead ? (w_dnew_pos ? c_sat_pos : c_sat_neg)
                                                : w_dnew;
                            if (w_n == r_max) begin
                                if (w_diff == '0) begin
                                    w_partita = c_draw;
                                end else if (w_diff[LW-1]) begin
                                    w_partita = c_p2;
                                end else begin
                                    w_partita = c_p1;
                                end
                                w_state = ST_OVER;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    w_manche = c_none;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_max       <= '0;
            r_num       <= '0;
            r_diff      <= '0;
            r_manche    <= c_none;
            r_partita   <= c_none;
            r_last_win  <= c_none;
            r_last_move <= 2'b00;
        end else begin
            r_state     <= w_state;
            r_max       <= w_max;
            r_num       <= w_num;
            r_diff      <= w_diff;
            r_manche    <= w_manche;
            r_partita   <= w_partita;
            r_last_win  <= w_last_win;
            r_last_move <= w_last_move;
        end
    end

    assign MANCHE     = r_manche;
    assign PARTITA    = r_partita;
    assign NUM_MANCHE = r_num;
    assign DIFF       = r_diff;

endmodule
`default_nettype wire
